load_store_unit: RTL and testbench

- MEM-stage load/store unit of the RV32 core.
- Takes the decoded memory op from the EX/MEM register and runs a ready/valid transaction on the data bus.
- Aligns and sign/zero-extends load data, then presents it as mem_rd_data to the writeback result selector.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: runs one ready/valid data-bus transaction per memory op,
// formats load data for writeback and stalls the pipeline while a transaction is in flight.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              lsu_stall,
  output logic              misaligned,
  output logic [31:0]       mem_rd_data,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;

  logic              misalignedC;
  logic              legal;
  logic              issue;
  logic [3:0]        stStrb;
  logic [31:0]       stData;
  logic [7:0]        ldByte;
  logic [15:0]       ldHalf;
  logic [31:0]       ldFmt;

  assign misalignedC = req_valid &
                       (((req_funct3[1:0] == 2'd1) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'd2) & (req_addr[1:0] != 2'b00)));
  assign legal = req_is_store ? (req_funct3 <= 3'd2)
                              : ((req_funct3 != 3'd3) & (req_funct3 <= 3'd5));
  assign issue = req_valid & ~flush & legal & ~misalignedC;

  // Stores replicate the source across lanes; strobes select the addressed bytes.
  always_comb begin
    stStrb = 4'b0000;
    stData = 32'h0;
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'd0: begin
          stStrb = 4'b0001 << req_addr[1:0];
          stData = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          stStrb = 4'b0011 << req_addr[1:0];
          stData = {2{req_wdata[15:0]}};
        end
        default: begin
          stStrb = 4'b1111;
          stData = req_wdata;
        end
      endcase
    end
  end

  assign ldByte = bus_rsp_data[{off_q, 3'b000} +: 8];
  assign ldHalf = off_q[1] ? bus_rsp_data[31:16] : bus_rsp_data[15:0];

  always_comb begin
    case (funct3_q)
      3'd0:    ldFmt = {{24{ldByte[7]}}, ldByte};
      3'd4:    ldFmt = {24'h0, ldByte};
      3'd1:    ldFmt = {{16{ldHalf[15]}}, ldHalf};
      3'd5:    ldFmt = {16'h0, ldHalf};
      default: ldFmt = bus_rsp_data;
    endcase
  end

  // A flush that lands on an accept or response still consumes that bus event,
  // so the FSM never waits for a response that has already gone by.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = REQ;
          we_d     = req_is_store;
          addr_d   = {req_addr[ADDR_W-1:2], 2'b00};
          wstrb_d  = stStrb;
          wdata_d  = stData;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            if (!we_q) begin
              rd_d = ldFmt;
            end
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus_rsp_valid) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'h0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      rd_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
    end
  end

  assign lsu_stall     = (issue & ((state_q == IDLE) | (state_q == REQ) | (state_q == WAIT))) |
                         (state_q == DRAIN);
  assign misaligned    = misalignedC;
  assign mem_rd_data   = rd_q;
  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases, then randomized
// transactions scored each cycle against a transaction-timeline reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        lsu_stall;
  logic        misaligned;
  logic [31:0] mem_rd_data;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_data;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_is_store  (req_is_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .lsu_stall     (lsu_stall),
    .misaligned    (misaligned),
    .mem_rd_data   (mem_rd_data),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_data  (bus_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int failCount = 0;

  bit          checkEn = 0;
  logic        expStall, expMis, expBusReqValid, expWe;
  bit          expFields, expWdataChk;
  logic [31:0] expAddr, expWdata, expRd;
  logic [3:0]  expStrb;
  logic        snapWe;
  logic [31:0] snapAddr, snapWdata;
  logic [3:0]  snapStrb;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("lsu_stall", 32'(lsu_stall), 32'(expStall));
      checkOutput("misaligned", 32'(misaligned), 32'(expMis));
      checkOutput("bus_req_valid", 32'(bus_req_valid), 32'(expBusReqValid));
      checkOutput("mem_rd_data", mem_rd_data, expRd);
      if (expFields) begin
        checkOutput("bus_we", 32'(bus_we), 32'(expWe));
        checkOutput("bus_addr", bus_addr, expAddr);
        checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(expStrb));
        if (expWdataChk) checkOutput("bus_wdata", bus_wdata, expWdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelLegal(input logic st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit modelMis(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (f3[1:0] == 2'd1) return (off % 2) != 0;
    if (f3[1:0] == 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
    int unsigned off, v;
    off = addr % 4;
    v = w;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [3:0] strb, output logic [31:0] data);
    int unsigned off, bytes;
    off = addr % 4;
    bytes = 1 << f3;
    strb = 4'(((1 << bytes) - 1) << off);
    if (f3 == 3'd0)      data = (wd & 32'hFF) * 32'h01010101;
    else if (f3 == 3'd1) data = (wd & 32'hFFFF) * 32'h00010001;
    else                 data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    req_valid = 1'b0;
    flush = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    expStall = 1'b0;
    expMis = 1'b0;
    expBusReqValid = 1'b0;
    expFields = 0;
    expWdataChk = 0;
  endtask

  // flushMode: 0 none, 1 flush in first REQ cycle (readyDelay>0), 2 flush in first WAIT cycle, 3 flush at issue
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int readyDelay, input int rspDelay,
                               input logic [31:0] rword, input int flushMode);
    logic [3:0]  s;
    logic [31:0] d;
    bit ok;
    ok = modelLegal(st, f3) && !modelMis(f3, addr) && (flushMode != 3);
    req_valid = 1'b1;
    req_is_store = st;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    flush = (flushMode == 3);
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    expMis = modelMis(f3, addr);
    expBusReqValid = 1'b0;
    expFields = 0;
    expWdataChk = 0;
    expStall = ok;
    step();
    if (!ok) begin
      setIdle();
      return;
    end
    if (st) modelStore(f3, addr, wd, s, d);
    else begin
      s = 4'b0000;
      d = 32'h0;
    end
    expMis = 1'b0;
    expBusReqValid = 1'b1;
    expFields = 1;
    expWdataChk = st;
    expWe = st;
    expAddr = addr & 32'hFFFFFFFC;
    expStrb = s;
    expWdata = d;
    expStall = 1'b1;
    snapWe = bus_we;
    snapAddr = bus_addr;
    snapStrb = bus_wstrb;
    snapWdata = bus_wdata;
    for (int i = 0; i < readyDelay; i++) begin
      bus_rsp_valid = 1'($urandom_range(0, 1));
      bus_rsp_data = $urandom;
      if (flushMode == 1) begin
        flush = 1'b1;
        expStall = 1'b0;
        step();
        setIdle();
        return;
      end
      step();
    end
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    expBusReqValid = 1'b0;
    expFields = 0;
    expWdataChk = 0;
    if (flushMode == 2) begin
      flush = 1'b1;
      expStall = 1'b0;
      step();
      flush = 1'b0;
      req_valid = 1'b0;
      expStall = 1'b1;
      for (int i = 1; i < rspDelay; i++) step();
      bus_rsp_valid = 1'b1;
      bus_rsp_data = rword;
      step();
      setIdle();
      return;
    end
    for (int i = 1; i < rspDelay; i++) step();
    bus_rsp_valid = 1'b1;
    bus_rsp_data = rword;
    step();
    bus_rsp_valid = 1'b0;
    if (!st) expRd = modelLoad(f3, addr, rword);
    expStall = 1'b0;
    step();
    setIdle();
  endtask

  task automatic resetDuringReq();
    logic [3:0]  s;
    logic [31:0] d;
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h40;
    req_wdata = 32'hCAFEF00D;
    flush = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    expStall = 1'b1;
    expMis = 1'b0;
    expBusReqValid = 1'b0;
    step();
    modelStore(3'd2, 32'h40, 32'hCAFEF00D, s, d);
    expBusReqValid = 1'b1;
    expFields = 1;
    expWdataChk = 1;
    expWe = 1'b1;
    expAddr = 32'h40;
    expStrb = s;
    expWdata = d;
    rst_n = 1'b0;
    step();
    setIdle();
    expRd = 32'h0;
    expFields = 1;
    expWdataChk = 1;
    expWe = 1'b0;
    expAddr = 32'h0;
    expStrb = 4'b0000;
    expWdata = 32'h0;
    step();
    rst_n = 1'b1;
    setIdle();
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          rd, rsp, fm, r;
    rst_n = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    bus_rsp_data = 32'h0;
    setIdle();
    expRd = 32'h0;
    expFields = 1;
    expWe = 1'b0;
    expAddr = 32'h0;
    expStrb = 4'b0000;
    expWdata = 32'h0;
    expWdataChk = 1;
    step();
    checkEn = 1;
    step();
    rst_n = 1'b1;
    setIdle();
    step();

    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    checkOutput("lw_rd_literal", mem_rd_data, 32'hDEADBEEF);
    checkOutput("lw_addr_literal", snapAddr, 32'h100);
    checkOutput("lw_wstrb_literal", 32'(snapStrb), 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h203, 32'h0, 0, 1, 32'h80FFFFFF, 0);
    checkOutput("lb_rd_literal", mem_rd_data, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'd4, 32'h203, 32'h0, 1, 2, 32'h80FFFFFF, 0);
    checkOutput("lbu_rd_literal", mem_rd_data, 32'h00000080);
    applyStimulus(1'b0, 3'd5, 32'h202, 32'h0, 0, 1, 32'h80FFFFFF, 0);
    checkOutput("lhu_rd_literal", mem_rd_data, 32'h000080FF);
    applyStimulus(1'b1, 3'd1, 32'h12, 32'h1234ABCD, 0, 1, 32'h0, 0);
    checkOutput("sh_addr_literal", snapAddr, 32'h10);
    checkOutput("sh_wstrb_literal", 32'(snapStrb), 32'hC);
    checkOutput("sh_wdata_literal", snapWdata, 32'hABCDABCD);
    checkOutput("sh_we_literal", 32'(snapWe), 32'h1);
    checkOutput("sh_rd_unchanged", mem_rd_data, 32'h000080FF);
    applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h0, 0);
    applyStimulus(1'b0, 3'd2, 32'h300, 32'h0, 5, 1, 32'h0BADF00D, 0);
    checkOutput("slow_ready_rd_literal", mem_rd_data, 32'h0BADF00D);
    applyStimulus(1'b0, 3'd2, 32'h304, 32'h0, 0, 2, 32'h55555555, 2);
    checkOutput("drain_rd_literal", mem_rd_data, 32'h0BADF00D);
    applyStimulus(1'b0, 3'd2, 32'h308, 32'h0, 2, 1, 32'h12345678, 1);
    resetDuringReq();
    checkOutput("reset_rd_literal", mem_rd_data, 32'h0);

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (st) f3 = 3'($urandom_range(0, 2));
        else begin
          r = $urandom_range(0, 4);
          f3 = (r >= 3) ? 3'(r + 1) : 3'(r);
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr = $urandom & 32'h00000FFF;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'd2) addr = addr & 32'hFFFFFFFC;
        else if (f3[1:0] == 2'd1) addr = addr & 32'hFFFFFFFE;
      end
      rd = $urandom_range(0, 3);
      rsp = $urandom_range(1, 3);
      r = $urandom_range(0, 9);
      fm = 0;
      if (r == 0) fm = 3;
      else if (r == 1 && rd > 0) fm = 1;
      else if (r == 2) fm = 2;
      applyStimulus(st, f3, addr, $urandom, rd, rsp, $urandom, fm);
      if ($urandom_range(0, 4) == 0) step();
    end

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
